// File: rtl/mem_arbiter_if.sv
// One cache-style memory port: request, write-data and in-order read-response channels.
// The requester side (cache or arbiter facing memory) uses master; the responder side uses slave.
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_rw;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging the icache (p0) and dcache (p1) memory ports onto one memory port;
// an owner FIFO steers in-order read responses back to the port that issued each read.
module mem_arbiter #(
  parameter int ADDR_BITS       = 28,
  parameter int DATA_BITS       = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  p0,
  mem_arbiter_if.slave  p1,
  mem_arbiter_if.master mem,
  output logic          err_unexpected_resp_o
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, WDATA = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             wowner_q, wowner_d;
  logic             last_grant_q, last_grant_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             fifo_q [MAX_OUTSTANDING];

  logic [1:0] vld, wr, elig;
  logic       fifo_full, fifo_empty;
  logic       gnt, port, gnt_ok, idle_wr, dv_sel, data_rdy;
  logic       req_hs, data_hs, push, pop, head;

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign vld        = {p1.req_valid, p0.req_valid};
  assign wr         = {p1.req_rw, p0.req_rw};
  // Reads need a free owner slot; writes never occupy one.
  assign elig       = vld & (wr | {2{~fifo_full}});

  always_comb begin
    gnt = vld[1];
    if (vld[0] && vld[1]) gnt = ~last_grant_q;
    if (!elig[gnt] && elig[~gnt] && wr[~gnt]) gnt = ~gnt;
  end

  assign port    = (state_q == WDATA) ? wowner_q : gnt;
  assign gnt_ok  = ~reset & (state_q == IDLE) & elig[gnt];
  assign idle_wr = gnt_ok & wr[gnt] & mem.req_ready;
  assign dv_sel  = port ? p1.req_data_valid : p0.req_data_valid;

  assign mem.req_valid     = gnt_ok;
  assign mem.req_addr      = port ? p1.req_addr      : p0.req_addr;
  assign mem.req_rw        = port ? p1.req_rw        : p0.req_rw;
  assign mem.req_data_bits = port ? p1.req_data_bits : p0.req_data_bits;
  assign mem.req_data_mask = port ? p1.req_data_mask : p0.req_data_mask;

  // In IDLE write data may only move together with its request handshake.
  assign mem.req_data_valid = (state_q == WDATA) ? (~reset & dv_sel) : (idle_wr & dv_sel);
  assign data_rdy           = (state_q == WDATA) ? (~reset & mem.req_data_ready)
                                                 : (idle_wr & mem.req_data_ready);

  assign req_hs  = gnt_ok & mem.req_ready;
  assign data_hs = mem.req_data_valid & mem.req_data_ready;

  assign p0.req_ready      = req_hs & ~gnt;
  assign p1.req_ready      = req_hs & gnt;
  assign p0.req_data_ready = data_rdy & ~port;
  assign p1.req_data_ready = data_rdy & port;

  assign head = fifo_q[rd_ptr_q];
  assign pop  = ~reset & mem.resp_valid & ~fifo_empty;
  assign push = req_hs & ~wr[gnt];

  assign p0.resp_valid = pop & ~head;
  assign p1.resp_valid = pop & head;
  assign p0.resp_data  = mem.resp_data;
  assign p1.resp_data  = mem.resp_data;

  assign err_unexpected_resp_o = err_q;

  always_comb begin
    state_d      = state_q;
    wowner_d     = wowner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | (mem.resp_valid & fifo_empty);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    if (req_hs) last_grant_d = gnt;
    case (state_q)
      IDLE: begin
        if (req_hs && wr[gnt] && !data_hs) begin
          state_d  = WDATA;
          wowner_d = gnt;
        end
      end
      WDATA: begin
        if (data_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wowner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      wowner_q     <= wowner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Owner storage is only meaningful below count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= gnt;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory request arbiter between the instruction cache and data cache and the single external memory interface. Each cache-side port mirrors the memory port the caches already drive (request, write-data and response channels, 128-bit beats, 28-bit beat address). Requests are granted round-robin. A write's data handshake completes before the grant moves. An owner FIFO records each accepted read so in-order memory responses return to the cache that issued them.

## Interface
Parameters:
- ADDR_BITS, 28, beat address width (word address minus 2 offset bits)
- DATA_BITS, 128, beat width; mask width DATA_BITS/8
- MAX_OUTSTANDING, 4, owner FIFO depth (power of two, ≥2)

Ports (pN = p0 icache, p1 dcache; repeated per port):
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk
- reset  in  1  synchronous active-high reset
- pN_req_valid  in  1  request valid
- pN_req_ready  out  1  request accepted this cycle
- pN_req_addr  in  ADDR_BITS  beat address
- pN_req_rw  in  1  1 = write, 0 = read
- pN_req_data_valid  in  1  write data valid
- pN_req_data_ready  out  1  write data accepted
- pN_req_data_bits  in  DATA_BITS  write data
- pN_req_data_mask  in  DATA_BITS/8  byte enables
- pN_resp_valid  out  1  read response for this port
- pN_resp_data  out  DATA_BITS  read data, mem_resp_data broadcast
- mem_req_valid / mem_req_ready / mem_req_addr / mem_req_rw  out/in/out/out  1/1/ADDR_BITS/1  memory request channel
- mem_req_data_valid / mem_req_data_ready / mem_req_data_bits / mem_req_data_mask  out/in/out/out  1/1/DATA_BITS/DATA_BITS/8  memory write-data channel
- mem_resp_valid / mem_resp_data  in/in  1/DATA_BITS  in-order read responses
- err_unexpected_resp  out  1  sticky; response arrived with owner FIFO empty

## Operation
- States: IDLE, WDATA. Registers: state, wowner, last_grant, owner FIFO, err flag.
- IDLE grant: if exactly one pN_req_valid, grant it; if both, grant port ≠ last_grant. Granted port's request and data channels go combinationally to memory. Ungranted port sees req_ready=0, data_ready=0.
- Read eligibility: a read is presented to memory only if the FIFO is not full. With the FIFO full, mem_req_valid=0 for a granted read. A full FIFO with a same-cycle pop still blocks.
- Write eligibility: writes are presented regardless of FIFO level.
- Grant fallback: if the granted port is an ineligible read and the other port holds an eligible write, the write is granted instead.
- Accept: request handshake is mem_req_valid & mem_req_ready. On accept, last_grant ← granted port.
- Read accept: push owner id into the FIFO.
- Write accept: if the data handshake (mem_req_data_valid & mem_req_data_ready) also completes that cycle, stay IDLE. Otherwise go WDATA, wowner ← port.
- WDATA: grant locked to wowner. Only the data channel is forwarded; mem_req_valid=0, other port fully stalled. Data handshake → IDLE.
- Data-before-request: a data handshake in IDLE without a request handshake is not allowed. data_ready is gated by mem_req_ready in IDLE.
- Response: on mem_resp_valid, pop FIFO head and assert that port's resp_valid for the same cycle. A push and pop in the same cycle are both honoured; count is unchanged.
- Unexpected response: mem_resp_valid with the FIFO empty sets err_unexpected_resp, which holds until reset. No pN_resp_valid is asserted.
- Pointers wrap modulo MAX_OUTSTANDING. Count width is log2(MAX_OUTSTANDING)+1.

## Timing
- Request and data paths are combinational: zero added latency. Response routing is zero latency; pN_resp_valid is in the same cycle as mem_resp_valid.
- Ready is never registered: pN_req_ready = grant & eligible & mem_req_ready.
- Reset (synchronous, takes effect at the clk edge with reset=1):
  - state=IDLE, FIFO empty, last_grant=1 (p0 wins the first tie), err=0.
  - While reset=1, all ready/valid outputs are 0.
- Reset mid-WDATA or with reads outstanding discards all state. Responses after reset with the FIFO empty set err.
- Fairness: with both ports continuously requesting and memory always ready, grants alternate every accept.

## Test plan
- Single read on p0, addr 0x0000010, mem_resp_data 0xAA..AA three cycles later → p0_resp_valid=1 that cycle with data 0xAA..AA; p1_resp_valid=0.
- Both ports read every cycle, memory always ready → grants p0,p1,p0,p1. Responses 1..4 route to p0,p1,p0,p1.
- p1 write with mem_req_data_ready held low 3 cycles after request accept → state WDATA, p0 read stalled with p0_req_ready=0. On data accept → IDLE, then p0 is granted.
- Four p0 reads accepted with no responses → fifth read blocked (mem_req_valid=0). A p1 write in the same cycle is granted. First response frees a slot.
- mem_resp_valid pulse with FIFO empty → err_unexpected_resp=1 and stays 1; reset clears it to 0.
- Reset asserted during WDATA with 2 reads outstanding → next cycle IDLE, FIFO empty, all readies 0 during reset; a new p0 read is then accepted immediately.
